// File: rtl/button_event_decoder_pkg.sv
// Shared definitions for the button event decoder: state encoding and
// default timing constants (kept in line with the debouncer timing).
package button_event_decoder_pkg;

  // FSM state encoding; 2'd3 is unused and recovers to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } state_t;

  // Default timing at 50 MHz: 1 s to long-press, 200 ms between repeats.
  localparam int LONG_CYCLES_DEF   = 50_000_000;
  localparam int REPEAT_CYCLES_DEF = 10_000_000;
  localparam int CNT_W_DEF         = 26;

endpackage : button_event_decoder_pkg

// File: rtl/button_event_decoder_if.sv
// Button line and decoded event outputs, bundled for the decoder port list.
// slave: the decoder itself. master: whoever drives the button level and
// consumes the events.
interface button_event_decoder_if;

  logic i_Data;     // debounced level, 1 = released, 0 = pressed
  logic o_Press;    // one-cycle pulse on press
  logic o_Release;  // one-cycle pulse on release
  logic o_Long;     // one-cycle pulse when long-press is reached
  logic o_Repeat;   // one-cycle pulse per auto-repeat while held
  logic o_Held;     // level, high while in the long-press held state

  modport slave (
    input  i_Data,
    output o_Press,
    output o_Release,
    output o_Long,
    output o_Repeat,
    output o_Held
  );

  modport master (
    output i_Data,
    input  o_Press,
    input  o_Release,
    input  o_Long,
    input  o_Repeat,
    input  o_Held
  );

endinterface : button_event_decoder_if

// File: rtl/button_event_decoder_interval.sv
// Interval counter: clearable, enabled up-counter with an equality compare
// against a terminal value supplied by the caller. The caller clears it on
// every threshold and state change, so it never needs to wrap.
module interval_counter #(
  parameter int CNT_W = 4
) (
  input  logic             i_CLK,
  input  logic             i_RSTn,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] terminal,
  output logic             at_terminal
);

  logic [CNT_W-1:0] cnt_reg;

  // Count register: clear has priority over enable.
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign at_terminal = (cnt_reg == terminal);

endmodule : interval_counter

// File: rtl/button_event_decoder.sv
// Button event decoder: turns a debounced active-low button level into
// single-cycle press / release / long-press / auto-repeat pulses plus a
// held level. All outputs are registered; at most one pulse per cycle.
module button_event_decoder
  import button_event_decoder_pkg::*;
#(
  parameter int LONG_CYCLES   = LONG_CYCLES_DEF,    // >= 2
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF,  // >= 1
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic                   i_CLK,
  input  logic                   i_RSTn,
  button_event_decoder_if.slave  bus
);

  // The counter starts at 0 on the cycle after the entering edge, so the
  // threshold edge sees a count of N-1.
  localparam logic [CNT_W-1:0] LONG_TERM   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_TERM = CNT_W'(REPEAT_CYCLES - 1);

  state_t state_reg, state_next;

  logic press_reg,   press_next;
  logic release_reg, release_next;
  logic long_reg,    long_next;
  logic repeat_reg,  repeat_next;
  logic held_reg,    held_next;

  logic             cnt_clr;
  logic             cnt_en;
  logic [CNT_W-1:0] cnt_terminal;
  logic             cnt_at_terminal;

  interval_counter #(
    .CNT_W (CNT_W)
  ) u_interval (
    .i_CLK       (i_CLK),
    .i_RSTn      (i_RSTn),
    .clr         (cnt_clr),
    .en          (cnt_en),
    .terminal    (cnt_terminal),
    .at_terminal (cnt_at_terminal)
  );

  // State and output registers; reset forces everything quiet immediately.
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      state_reg   <= ST_IDLE;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
      long_reg    <= 1'b0;
      repeat_reg  <= 1'b0;
      held_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      press_reg   <= press_next;
      release_reg <= release_next;
      long_reg    <= long_next;
      repeat_reg  <= repeat_next;
      held_reg    <= held_next;
    end
  end

  // Next state, next outputs and counter control; release beats thresholds.
  always_comb begin
    state_next   = state_reg;
    press_next   = 1'b0;
    release_next = 1'b0;
    long_next    = 1'b0;
    repeat_next  = 1'b0;
    cnt_clr      = 1'b0;
    cnt_en       = 1'b0;
    cnt_terminal = LONG_TERM;

    case (state_reg)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (!bus.i_Data) begin
          state_next = ST_PRESSED;
          press_next = 1'b1;
        end
      end

      ST_PRESSED: begin
        cnt_terminal = LONG_TERM;
        if (bus.i_Data) begin
          state_next   = ST_IDLE;
          release_next = 1'b1;
          cnt_clr      = 1'b1;
        end else if (cnt_at_terminal) begin
          state_next = ST_HELD;
          long_next  = 1'b1;
          cnt_clr    = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end

      ST_HELD: begin
        cnt_terminal = REPEAT_TERM;
        if (bus.i_Data) begin
          state_next   = ST_IDLE;
          release_next = 1'b1;
          cnt_clr      = 1'b1;
        end else if (cnt_at_terminal) begin
          repeat_next = 1'b1;
          cnt_clr     = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end

      default: begin
        state_next = ST_IDLE;
        cnt_clr    = 1'b1;
      end
    endcase

    held_next = (state_next == ST_HELD);
  end

  assign bus.o_Press   = press_reg;
  assign bus.o_Release = release_reg;
  assign bus.o_Long    = long_reg;
  assign bus.o_Repeat  = repeat_reg;
  assign bus.o_Held    = held_reg;

endmodule : button_event_decoder

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with LONG_CYCLES=8,
// REPEAT_CYCLES=4, CNT_W=4. Inputs change on the falling edge, outputs are
// compared on the falling edge after each rising edge. Expected vectors are
// {press, release, long, repeat, held}.
module tb_button_event_decoder;

  localparam logic [4:0] E_NONE = 5'b00000;
  localparam logic [4:0] E_P    = 5'b10000;
  localparam logic [4:0] E_R    = 5'b01000;
  localparam logic [4:0] E_L    = 5'b00100;
  localparam logic [4:0] E_RP   = 5'b00010;
  localparam logic [4:0] E_H    = 5'b00001;

  logic i_CLK;
  logic i_RSTn;
  int   checks;
  int   failures;

  button_event_decoder_if bus();

  button_event_decoder #(
    .LONG_CYCLES   (8),
    .REPEAT_CYCLES (4),
    .CNT_W         (4)
  ) dut (
    .i_CLK  (i_CLK),
    .i_RSTn (i_RSTn),
    .bus    (bus)
  );

  initial begin
    i_CLK = 1'b0;
    forever #5 i_CLK = ~i_CLK;
  end

  function automatic logic [4:0] outs();
    return {bus.o_Press, bus.o_Release, bus.o_Long, bus.o_Repeat, bus.o_Held};
  endfunction

  task automatic check_eq(input string tag, input logic [4:0] got,
                          input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b expected=%b (P R L RP H)", tag, got, exp);
    end else begin
      $display("ok   %s got=%b", tag, got);
    end
  endtask

  // Drive one level, let one rising edge sample it, compare the result.
  task automatic step(input logic d, input logic [4:0] exp, input string tag);
    bus.i_Data = d;
    @(posedge i_CLK);
    @(negedge i_CLK);
    check_eq(tag, outs(), exp);
  endtask

  initial begin
    logic [4:0] exp;
    checks      = 0;
    failures    = 0;
    i_RSTn      = 1'b0;
    bus.i_Data  = 1'b0;

    // 1: reset held with button pressed, then released with button idle
    @(negedge i_CLK);
    for (int i = 0; i < 3; i++) step(1'b0, E_NONE, $sformatf("s1_rst[%0d]", i));
    i_RSTn = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, E_NONE, $sformatf("s1_post[%0d]", i));

    // 2: short press, five low samples then high
    step(1'b0, E_P, "s2_press");
    for (int i = 1; i < 5; i++) step(1'b0, E_NONE, $sformatf("s2_low[%0d]", i));
    step(1'b1, E_R, "s2_release");
    step(1'b1, E_NONE, "s2_idle");

    // 3: long hold, long at t+8, repeats at t+12, t+16, t+20
    for (int i = 0; i <= 20; i++) begin
      if (i == 0)      exp = E_P;
      else if (i < 8)  exp = E_NONE;
      else if (i == 8) exp = E_L | E_H;
      else if (((i - 8) % 4) == 0) exp = E_RP | E_H;
      else             exp = E_H;
      step(1'b0, exp, $sformatf("s3_hold[t+%0d]", i));
    end
    step(1'b1, E_R, "s3_release");
    step(1'b1, E_NONE, "s3_idle");

    // 4: release on the edge that would fire long
    step(1'b0, E_P, "s4_press");
    for (int i = 1; i < 8; i++) step(1'b0, E_NONE, $sformatf("s4_low[%0d]", i));
    step(1'b1, E_R, "s4_release_wins");
    step(1'b1, E_NONE, "s4_idle");

    // 5: asynchronous reset while held, then a fresh press
    step(1'b0, E_P, "s5_press");
    for (int i = 1; i <= 10; i++) begin
      exp = (i < 8) ? E_NONE : ((i == 8) ? (E_L | E_H) : E_H);
      step(1'b0, exp, $sformatf("s5_hold[t+%0d]", i));
    end
    #2 i_RSTn = 1'b0;
    #1 check_eq("s5_async_drop", outs(), E_NONE);
    @(posedge i_CLK);
    @(negedge i_CLK);
    check_eq("s5_in_reset", outs(), E_NONE);
    i_RSTn = 1'b1;
    step(1'b0, E_P, "s5_fresh_press");
    step(1'b1, E_R, "s5_release");
    step(1'b1, E_NONE, "s5_idle");

    // 6: single-cycle glitches, every edge honoured
    step(1'b1, E_NONE, "s6_g0");
    step(1'b0, E_P,    "s6_g1");
    step(1'b1, E_R,    "s6_g2");
    step(1'b0, E_P,    "s6_g3");
    step(1'b1, E_R,    "s6_g4");
    step(1'b1, E_NONE, "s6_g5");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_button_event_decoder
